// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: widths, lock FSM states, command record.
package dmem_arb_pkg;

    localparam int NPORTS = 2;
    localparam int AW     = 13;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic          valid;
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    // Ports allowed to compete for a grant in a given lock state.
    function automatic logic [NPORTS-1:0] lock_mask(input arb_state_e st);
        case (st)
            ST_LOCK0: lock_mask = 2'b01;
            ST_LOCK1: lock_mask = 2'b10;
            default:  lock_mask = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side signals of the arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic          req0, req1;
    logic          we0, we1;
    logic          lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_memread, mem_memwrite;
    logic [DW-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  mem_read_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_address, mem_write_data, mem_memread, mem_memwrite
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output mem_read_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_address, mem_write_data, mem_memread, mem_memwrite
    );

endinterface

// File: rtl/dmem_arb_grant.sv
// Winner select for two requesters; round-robin pointer when DMEM_ARB_RR_EN is defined,
// otherwise fixed priority to port 0.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic              clk,
    input  logic              srst,
`endif
    input  logic [NPORTS-1:0] req_i,
    output logic [NPORTS-1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i == 2'b11) begin
            gnt_o        = '0;
            gnt_o[ptr_q] = 1'b1;
        end
        // Pointer moves to the port that did not win this grant.
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_o = req_i;
        if (req_i[0]) begin
            gnt_o[1] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and A/M/R sequencer for the single-port data memory, with lock
// sequences for read-modify-write. DMEM_ARB_RR_EN selects round-robin contest resolution.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    arb_state_e                     state_q;
    logic                           ready_q;
    cmd_t                           cmd_q, cmd_d;
    logic [NPORTS-1:0]              req_vec, eligible, gnt;
    logic [NPORTS-1:0]              rvalid_vec;
    logic [NPORTS-1:0][DW-1:0]      rdata_vec;

    assign req_vec = {bus.req1, bus.req0};

    // No grant while in reset nor in the first cycle after it is released.
    assign eligible = (rst || !ready_q) ? '0 : (req_vec & lock_mask(state_q));

    dmem_arb_grant u_grant (
`ifdef DMEM_ARB_RR_EN
        .clk   (clk),
        .srst  (rst),
`endif
        .req_i (eligible),
        .gnt_o (gnt)
    );

    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];

    always_comb begin
        cmd_d = '0;
        if (gnt[1]) begin
            cmd_d = '{valid: 1'b1, port: 1'b1, we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
        end else if (gnt[0]) begin
            cmd_d = '{valid: 1'b1, port: 1'b0, we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            ready_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            cmd_q   <= cmd_d;
            case (state_q)
                ST_ARB: begin
                    if (gnt[0] && bus.lock0) begin
                        state_q <= ST_LOCK0;
                    end else if (gnt[1] && bus.lock1) begin
                        state_q <= ST_LOCK1;
                    end
                end
                ST_LOCK0: begin
                    if (!bus.req0 || (gnt[0] && !bus.lock0)) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_LOCK1: begin
                    if (!bus.req1 || (gnt[1] && !bus.lock1)) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Gating with rst keeps a write sitting in stage M from committing at the reset edge.
    assign bus.mem_memwrite   = !rst && cmd_q.valid && cmd_q.we;
    assign bus.mem_memread    = !rst && cmd_q.valid && !cmd_q.we;
    assign bus.mem_address    = rst ? '0 : cmd_q.addr;
    assign bus.mem_write_data = rst ? '0 : cmd_q.wdata;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            logic          rvalid_q;
            logic [DW-1:0] rdata_q;
            logic          capture;

            assign capture = cmd_q.valid && !cmd_q.we && (cmd_q.port == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= capture;
                    if (capture) begin
                        rdata_q <= bus.mem_read_data;
                    end
                end
            end

            assign rvalid_vec[gi] = rst ? 1'b0 : rvalid_q;
            assign rdata_vec[gi]  = rst ? '0 : rdata_q;
        end
    endgenerate

    assign bus.rvalid0 = rvalid_vec[0];
    assign bus.rvalid1 = rvalid_vec[1];
    assign bus.rdata0  = rdata_vec[0];
    assign bus.rdata1  = rdata_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a request-level reference model and a behavioural memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mem     [0:8191];
    logic [DW-1:0] ref_mem [0:8191];
    rd_exp_t       rdq[$];

    dmem_arbiter_if bus();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
        end else if (bus.mem_memwrite) begin
            mem[bus.mem_address] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = mem[bus.mem_address];

    task automatic idle;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_init = 1'b1;
        idle();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_memread, bus.mem_memwrite} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b%b rvalid=%b%b rd=%b wr=%b want all 0",
                     bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_memread, bus.mem_memwrite);
        end
        checks++;
        if (bus.rdata0 !== '0 || bus.rdata1 !== '0 || bus.mem_address !== '0 || bus.mem_write_data !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata0=%h rdata1=%h addr=%h wdata=%h want 0",
                     bus.rdata0, bus.rdata1, bus.mem_address, bus.mem_write_data);
        end
        // Release reset with a read already pending on port 0.
        next_cycle();
        rst = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_gnt got %b want 0", bus.gnt0);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL first_grant got %b want 1", bus.gnt0);
        end
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL first_read got rvalid0=%b rdata0=%h want 1/00000000", bus.rvalid0, bus.rdata0);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read;
        next_cycle();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 13'h0005; bus.wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL sr_write_gnt got %b%b want 10", bus.gnt0, bus.gnt1);
        end
        next_cycle();
        bus.we0 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_memwrite !== 1'b1 || bus.mem_address !== 13'h0005) begin
            errors++;
            $display("FAIL sr_read_gnt got gnt0=%b memwrite=%b addr=%h want 1/1/0005",
                     bus.gnt0, bus.mem_memwrite, bus.mem_address);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.mem_memread !== 1'b1 || bus.mem_memwrite !== 1'b0 || bus.mem_address !== 13'h0005) begin
            errors++;
            $display("FAIL sr_mstage got rd=%b wr=%b addr=%h want 1/0/0005",
                     bus.mem_memread, bus.mem_memwrite, bus.mem_address);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'hDEADBEEF || bus.rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL sr_rvalid got rvalid0=%b rdata0=%h rvalid1=%b want 1/deadbeef/0",
                     bus.rvalid0, bus.rdata0, bus.rvalid1);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sr_hold got rvalid0=%b rdata0=%h want 0/deadbeef", bus.rvalid0, bus.rdata0);
        end
        $display("test_single_read done");
    endtask

    task automatic test_back_to_back;
        next_cycle();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 13'h0000; bus.wdata1 = 32'h12345678;
        @(negedge clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_gnt got %b want 1", bus.gnt1);
        end
        next_cycle();
        bus.we1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read_gnt got %b want 1", bus.gnt1);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.rvalid1 !== 1'b0 || bus.mem_memread !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_write_rvalid got rvalid1=%b memread=%b want 0/1", bus.rvalid1, bus.mem_memread);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_read_data got rvalid1=%b rdata1=%h want 1/12345678", bus.rvalid1, bus.rdata1);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_contention;
        logic e0, e1;
        next_cycle();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.req0 = 1'b1; bus.addr0 = 13'h0001;
            bus.req1 = 1'b1; bus.addr1 = 13'h0002;
            @(negedge clk);
            e1 = RR_EN && (i % 2 == 1);
            e0 = !e1;
            checks++;
            if (bus.gnt0 !== e0 || bus.gnt1 !== e1) begin
                errors++;
                $display("FAIL contention_%0d got gnt=%b%b want %b%b", i, bus.gnt0, bus.gnt1, e0, e1);
            end
        end
        next_cycle();
        idle();
        repeat (3) next_cycle();
        $display("test_contention done");
    endtask

    task automatic test_lock;
        // Locked read, then unlocked write, while port 0 keeps asking.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1; bus.addr1 = 13'h0004;
        @(negedge clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_first_gnt got %b want 1", bus.gnt1);
        end
        next_cycle();
        bus.req0 = 1'b1; bus.addr0 = 13'h0004;
        bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.wdata1 = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold got gnt=%b%b want 01", bus.gnt0, bus.gnt1);
        end
        next_cycle();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_release_gnt got %b want 1", bus.gnt0);
        end
        // Lock dropped by the owner lowering its request.
        next_cycle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.lock1 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL lock2_gnt got %b want 1", bus.gnt1);
        end
        next_cycle();
        bus.req1 = 1'b0; bus.lock1 = 1'b0;
        bus.req0 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL lock2_exit_cycle got %b want 0", bus.gnt0);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL lock2_after got %b want 1", bus.gnt0);
        end
        next_cycle();
        idle();
        repeat (3) next_cycle();
        $display("test_lock done");
    endtask

    task automatic test_random;
        bit            rq[2], wq[2], lk[2], gl[2], eg[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        logic [DW-1:0] held[2];
        bit            exp_rv[2];
        bit            prev_rd, prev_wr;
        int            owner, favour, win;

        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        owner = -1; favour = 0; prev_rd = 0; prev_wr = 0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; wq[p] = 0; lk[p] = 0; gl[p] = 0;
            ad[p] = '0; wd[p] = '0; held[p] = '0;
        end
        rdq.delete();

        for (int cyc = 0; cyc < 312; cyc++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || gl[p]) begin
                    rq[p] = (cyc < 300) && ($urandom_range(0, 9) < 6);
                    wq[p] = ($urandom_range(0, 2) == 0);
                    lk[p] = ($urandom_range(0, 3) == 0);
                    ad[p] = AW'(16 + $urandom_range(0, 7));
                    wd[p] = $urandom;
                end
            end
            bus.req0 = rq[0]; bus.we0 = wq[0]; bus.lock0 = lk[0]; bus.addr0 = ad[0]; bus.wdata0 = wd[0];
            bus.req1 = rq[1]; bus.we1 = wq[1]; bus.lock1 = lk[1]; bus.addr1 = ad[1]; bus.wdata1 = wd[1];
            @(negedge clk);

            eg[0] = 0; eg[1] = 0;
            if (owner >= 0) eg[owner] = rq[owner];
            else if (rq[0] && rq[1]) eg[RR_EN ? favour : 0] = 1;
            else begin eg[0] = rq[0]; eg[1] = rq[1]; end
            checks++;
            if (bus.gnt0 !== eg[0] || bus.gnt1 !== eg[1]) begin
                errors++;
                $display("FAIL rand_gnt cyc=%0d got=%b%b want=%b%b", cyc, bus.gnt0, bus.gnt1, eg[0], eg[1]);
            end

            exp_rv[0] = 0; exp_rv[1] = 0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                exp_rv[rdq[0].port] = 1;
                held[rdq[0].port] = rdq[0].data;
                void'(rdq.pop_front());
            end
            checks++;
            if (bus.rvalid0 !== exp_rv[0] || bus.rvalid1 !== exp_rv[1] ||
                bus.rdata0 !== held[0] || bus.rdata1 !== held[1]) begin
                errors++;
                $display("FAIL rand_read cyc=%0d got rv=%b%b d0=%h d1=%h want rv=%b%b d0=%h d1=%h",
                         cyc, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                         exp_rv[0], exp_rv[1], held[0], held[1]);
            end
            checks++;
            if (bus.mem_memread !== prev_rd || bus.mem_memwrite !== prev_wr) begin
                errors++;
                $display("FAIL rand_mem_ctrl cyc=%0d got rd=%b wr=%b want rd=%b wr=%b",
                         cyc, bus.mem_memread, bus.mem_memwrite, prev_rd, prev_wr);
            end

            win = eg[0] ? 0 : (eg[1] ? 1 : -1);
            prev_rd = 0; prev_wr = 0;
            if (win >= 0) begin
                if (wq[win]) begin
                    ref_mem[ad[win]] = wd[win];
                    prev_wr = 1;
                end else begin
                    rdq.push_back(rd_exp_t'{due: cyc + 2, port: win, data: ref_mem[ad[win]]});
                    prev_rd = 1;
                end
                owner  = lk[win] ? win : -1;
                favour = 1 - win;
            end else if (owner >= 0 && !rq[owner]) begin
                owner = -1;
            end
            gl[0] = eg[0];
            gl[1] = eg[1];
        end
        checks++;
        if (rdq.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d reads outstanding want 0", rdq.size());
        end
        idle();
        $display("test_random done");
    endtask

    task automatic test_reset_mid_write;
        next_cycle();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 13'h0007; bus.wdata0 = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rmw_setup_gnt got %b want 1", bus.gnt0);
        end
        next_cycle();
        idle();
        next_cycle();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 13'h0007; bus.wdata0 = 32'h11111111;
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1 || mem[7] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rmw_second_gnt got gnt0=%b mem7=%h want 1/a5a5a5a5", bus.gnt0, mem[7]);
        end
        next_cycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_memwrite !== 1'b0 || bus.mem_memread !== 1'b0 ||
            bus.mem_address !== '0 || bus.mem_write_data !== '0) begin
            errors++;
            $display("FAIL rmw_suppress got wr=%b rd=%b addr=%h wdata=%h want 0",
                     bus.mem_memwrite, bus.mem_memread, bus.mem_address, bus.mem_write_data);
        end
        next_cycle();
        checks++;
        if (mem[7] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rmw_mem_keep got %h want a5a5a5a5", mem[7]);
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_memwrite} !== 5'b0 ||
            bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            errors++;
            $display("FAIL rmw_in_reset got gnt=%b%b rv=%b%b wr=%b d0=%h d1=%h want 0",
                     bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_memwrite, bus.rdata0, bus.rdata1);
        end
        next_cycle();
        idle();
        rst = 1'b0;
        $display("test_reset_mid_write done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_lock();
        test_random();
        test_reset_mid_write();
        repeat (2) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
